// File: rtl/reset_inject_seq.sv
// Programmable reset injector: one-shot, periodic or pseudo-random reset pulses on
// NUM_CH active-low outputs with staggered release and a post-release enable mask.
module reset_inject_seq #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STAGGER_W = 8,
  parameter int unsigned MASK_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inject_en,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     hold_cnt,
  input  logic [CNT_W-1:0]     period_cnt,
  input  logic [STAGGER_W-1:0] stagger,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [MASK_W-1:0]    en_mask_val,
  output logic [NUM_CH-1:0]    rst_n_out,
  output logic [MASK_W-1:0]    en_mask,
  output logic                 en_mask_vld,
  output logic                 busy,
  output logic [15:0]          event_cnt
);

  // Wide enough that hold + (NUM_CH-1)*stagger never wraps.
  localparam int unsigned TW        = CNT_W + STAGGER_W + 5;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_RELEASE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_CH-1:0]    ch_q_reg, ch_q_next;
  logic [1:0]           mode_reg, mode_next;
  logic [TW-1:0]        hold_reg, hold_next;
  logic [STAGGER_W-1:0] stag_reg, stag_next;
  logic [CNT_W-1:0]     period_reg, period_next;
  logic [MASK_W-1:0]    mask_lat_reg, mask_lat_next;
  logic [TW-1:0]        cnt_reg, cnt_next;
  logic [CNT_W-1:0]     wait_reg, wait_next;
  logic [CNT_W-1:0]     wcnt_reg, wcnt_next;
  logic                 aborted_reg, aborted_next;
  logic [MASK_W-1:0]    en_mask_reg, en_mask_next;
  logic                 vld_reg, vld_next;
  logic [15:0]          event_cnt_reg, event_cnt_next;
  logic [31:0]          lfsr_reg, lfsr_next;

  logic                 armed;
  logic                 latch_go;
  logic                 abort_now;
  logic                 in_release;
  logic [TW-1:0]        h_eff;
  logic [NUM_CH-1:0]    rel_hit;
  logic                 last_hit;
  logic [CNT_W-1:0]     p_sel;
  logic [CNT_W-1:0]     w_draw;

  assign armed      = inject_en && (mode != 2'd0);
  assign latch_go   = armed && ((state_reg == S_IDLE) ||
                                ((state_reg == S_WAIT) && (wcnt_reg == wait_reg)));
  assign abort_now  = (state_reg == S_ASSERT) && !inject_en;
  assign in_release = (state_reg == S_ASSERT) || (state_reg == S_RELEASE);

  // An abort rebases the release schedule onto the current cycle count.
  assign h_eff = abort_now ? cnt_reg : hold_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rel
      assign rel_hit[gi] = in_release &&
                           (cnt_reg == (h_eff + TW'(gi) * TW'(stag_reg)));
    end
  endgenerate

  assign last_hit = rel_hit[NUM_CH-1];

  assign p_sel  = (mode_reg == 2'd3) ? (lfsr_reg[CNT_W-1:0] & period_reg) : period_reg;
  assign w_draw = (p_sel == '0) ? CNT_W'(1) : p_sel;

  always_comb begin
    state_next     = state_reg;
    ch_q_next      = ch_q_reg;
    mode_next      = mode_reg;
    hold_next      = hold_reg;
    stag_next      = stag_reg;
    period_next    = period_reg;
    mask_lat_next  = mask_lat_reg;
    cnt_next       = cnt_reg;
    wait_next      = wait_reg;
    wcnt_next      = wcnt_reg;
    aborted_next   = aborted_reg;
    en_mask_next   = en_mask_reg;
    vld_next       = vld_reg;
    event_cnt_next = event_cnt_reg;
    lfsr_next      = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_POLY : 32'h0);

    unique case (state_reg)
      S_IDLE: begin
        if (latch_go) state_next = S_ASSERT;
      end
      S_ASSERT, S_RELEASE: begin
        cnt_next  = cnt_reg + TW'(1);
        ch_q_next = ch_q_reg | rel_hit;
        if (abort_now) begin
          hold_next    = h_eff;
          aborted_next = 1'b1;
        end
        if (last_hit) begin
          en_mask_next = mask_lat_reg;
          vld_next     = 1'b1;
          wait_next    = w_draw;
          wcnt_next    = CNT_W'(1);
          if (aborted_reg || abort_now) state_next = S_IDLE;
          else if (mode_reg == 2'd1)    state_next = S_DONE;
          else                          state_next = S_WAIT;
        end else if (rel_hit[0]) begin
          state_next = S_RELEASE;
        end
      end
      S_WAIT: begin
        if (!armed)        state_next = S_IDLE;
        else if (latch_go) state_next = S_ASSERT;
        else               wcnt_next  = wcnt_reg + CNT_W'(1);
      end
      S_DONE: begin
        if (!inject_en) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (latch_go) begin
      mode_next      = mode;
      hold_next      = (hold_cnt == '0) ? TW'(1) : TW'(hold_cnt);
      stag_next      = stagger;
      period_next    = period_cnt;
      mask_lat_next  = en_mask_val;
      ch_q_next      = ~ch_en;
      cnt_next       = TW'(1);
      aborted_next   = 1'b0;
      vld_next       = 1'b0;
      event_cnt_next = (event_cnt_reg == 16'hFFFF) ? event_cnt_reg : event_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      ch_q_reg      <= '1;
      mode_reg      <= 2'd0;
      hold_reg      <= '0;
      stag_reg      <= '0;
      period_reg    <= '0;
      mask_lat_reg  <= '0;
      cnt_reg       <= '0;
      wait_reg      <= '0;
      wcnt_reg      <= '0;
      aborted_reg   <= 1'b0;
      en_mask_reg   <= '0;
      vld_reg       <= 1'b0;
      event_cnt_reg <= 16'h0;
      lfsr_reg      <= LFSR_SEED;
    end else begin
      state_reg     <= state_next;
      ch_q_reg      <= ch_q_next;
      mode_reg      <= mode_next;
      hold_reg      <= hold_next;
      stag_reg      <= stag_next;
      period_reg    <= period_next;
      mask_lat_reg  <= mask_lat_next;
      cnt_reg       <= cnt_next;
      wait_reg      <= wait_next;
      wcnt_reg      <= wcnt_next;
      aborted_reg   <= aborted_next;
      en_mask_reg   <= en_mask_next;
      vld_reg       <= vld_next;
      event_cnt_reg <= event_cnt_next;
      lfsr_reg      <= lfsr_next;
    end
  end

  // External reset reaches the outputs without needing a clock.
  assign rst_n_out   = ch_q_reg & {NUM_CH{rst_n}};
  assign en_mask     = en_mask_reg;
  assign en_mask_vld = vld_reg;
  assign busy        = (state_reg != S_IDLE);
  assign event_cnt   = event_cnt_reg;

endmodule
